// File: rtl/useq_ctrl.sv
// useq_ctrl: microsequencer with writable control store, micro-PC and next-address logic.
// Optional micro-subroutine return stack is compiled in when UCODE_STACK_EN is defined.
module useq_ctrl #(
  parameter int unsigned UADDR_W     = 6,
  parameter int unsigned CTRL_W      = 11,
  parameter int unsigned OP_W        = 4,
  parameter int unsigned STACK_DEPTH = 4,
  localparam int unsigned WORD_W     = CTRL_W + UADDR_W + 6
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               ld_en_i,
  input  logic [UADDR_W-1:0] ld_addr_i,
  input  logic [WORD_W-1:0]  ld_data_i,
  output logic               instr_req_o,
  input  logic               instr_valid_i,
  input  logic [OP_W-1:0]    instr_op_i,
  input  logic [3:0]         flags_i,
  output logic [CTRL_W-1:0]  ctrl_o,
  output logic [UADDR_W-1:0] upc_o,
  output logic               busy_o,
  output logic               halted_o,
  output logic               uerr_o
);

  localparam int unsigned Depth = 2 ** UADDR_W;

  typedef enum logic [1:0] {StIdle, StRun, StWait, StHalt} state_e;
  typedef enum logic [2:0] {
    SeqNext     = 3'd0,
    SeqJump     = 3'd1,
    SeqBranch   = 3'd2,
    SeqDispatch = 3'd3,
    SeqFetch    = 3'd4,
    SeqCall     = 3'd5,
    SeqRet      = 3'd6,
    SeqHalt     = 3'd7
  } seq_e;

  logic [WORD_W-1:0]  store_q [Depth];
  state_e             state_q, state_d;
  logic [UADDR_W-1:0] upc_q, upc_d;
  logic [OP_W-1:0]    op_q, op_d;

  logic [WORD_W-1:0]  word;
  logic [UADDR_W-1:0] w_target;
  logic [1:0]         w_cond;
  logic               w_inv;
  seq_e               w_seq;
  logic [CTRL_W-1:0]  w_ctrl;
  logic [UADDR_W-1:0] upc_inc;
  logic               store_wr;

  assign word     = store_q[upc_q];
  assign w_target = word[UADDR_W-1:0];
  assign w_cond   = word[UADDR_W+1:UADDR_W];
  assign w_inv    = word[UADDR_W+2];
  assign w_seq    = seq_e'(word[UADDR_W+5:UADDR_W+3]);
  assign w_ctrl   = word[WORD_W-1:UADDR_W+6];
  assign upc_inc  = upc_q + UADDR_W'(1);

  // Store is only writable while the sequencer is parked.
  assign store_wr = ld_en_i && ((state_q == StIdle) || (state_q == StHalt));

  always_ff @(posedge clk_i) begin
    if (store_wr) begin
      store_q[ld_addr_i] <= ld_data_i;
    end
  end

`ifdef UCODE_STACK_EN
  localparam int unsigned SpW = $clog2(STACK_DEPTH + 1);

  logic [UADDR_W-1:0] stack_q [2**SpW];
  logic [SpW-1:0]     sp_q, sp_d, sp_dec;
  logic               uerr_q, uerr_d;
  logic               push;
  logic               stk_full, stk_empty;

  assign sp_dec    = sp_q - SpW'(1);
  assign stk_full  = (sp_q == SpW'(STACK_DEPTH));
  assign stk_empty = (sp_q == '0);
  assign uerr_o    = uerr_q;

  always_ff @(posedge clk_i) begin
    if (push) begin
      stack_q[sp_q] <= upc_inc;
    end
  end
`else
  assign uerr_o = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    upc_d       = upc_q;
    op_d        = op_q;
    ctrl_o      = '0;
    instr_req_o = 1'b0;
`ifdef UCODE_STACK_EN
    sp_d        = sp_q;
    uerr_d      = uerr_q;
    push        = 1'b0;
`endif
    unique case (state_q)
      StIdle, StHalt: begin
        if (start_i) begin
          state_d = StRun;
          upc_d   = '0;
`ifdef UCODE_STACK_EN
          uerr_d  = 1'b0;
`endif
        end
      end
      StRun: begin
        ctrl_o = w_ctrl;
        unique case (w_seq)
          SeqNext:     upc_d = upc_inc;
          SeqJump:     upc_d = w_target;
          SeqBranch:   upc_d = (flags_i[w_cond] ^ w_inv) ? w_target : upc_inc;
          SeqDispatch: upc_d = w_target + UADDR_W'(op_q);
          SeqFetch: begin
            instr_req_o = 1'b1;
            if (instr_valid_i) begin
              op_d  = instr_op_i;
              upc_d = w_target;
            end else begin
              state_d = StWait;
            end
          end
`ifdef UCODE_STACK_EN
          SeqCall: begin
            if (stk_full) begin
              uerr_d  = 1'b1;
              state_d = StHalt;
            end else begin
              push  = 1'b1;
              sp_d  = sp_q + SpW'(1);
              upc_d = w_target;
            end
          end
          SeqRet: begin
            if (stk_empty) begin
              uerr_d  = 1'b1;
              state_d = StHalt;
            end else begin
              sp_d  = sp_dec;
              upc_d = stack_q[sp_dec];
            end
          end
`else
          SeqCall:     upc_d = upc_inc;
          SeqRet:      upc_d = upc_inc;
`endif
          SeqHalt:     state_d = StHalt;
          default:     state_d = StHalt;
        endcase
      end
      StWait: begin
        instr_req_o = 1'b1;
        // upc still points at the FETCH word, so its target is still on w_target.
        if (instr_valid_i) begin
          op_d    = instr_op_i;
          upc_d   = w_target;
          state_d = StRun;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      upc_q   <= '0;
      op_q    <= '0;
`ifdef UCODE_STACK_EN
      sp_q    <= '0;
      uerr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      upc_q   <= upc_d;
      op_q    <= op_d;
`ifdef UCODE_STACK_EN
      sp_q    <= sp_d;
      uerr_q  <= uerr_d;
`endif
    end
  end

  assign upc_o    = upc_q;
  assign busy_o   = (state_q == StRun) || (state_q == StWait);
  assign halted_o = (state_q == StHalt);

endmodule
